// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller: FSM state, latch control word,
// counter width and the load-use hazard test.
package pipeline_ctrl_pkg;

   localparam int unsigned CNT_W = 16;
   localparam int unsigned REG_W = 5;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MEMWAIT = 2'd1,
      HALT    = 2'd2
   } ctrl_state_t;

   // One control word covering the PC and all four pipeline latches
   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic ifid_flush;
      logic idex_en;
      logic idex_flush;
      logic idex_freeze;
      logic exmem_en;
      logic exmem_flush;
      logic memwb_en;
      logic memwb_flush;
   } ctrl_t;

   localparam ctrl_t CTRL_ALL_OFF = '0;

   localparam ctrl_t CTRL_ADVANCE = '{
      pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0,
      idex_en: 1'b1, idex_flush: 1'b0, idex_freeze: 1'b0,
      exmem_en: 1'b1, exmem_flush: 1'b0,
      memwb_en: 1'b1, memwb_flush: 1'b0
   };

   // Destination register 0 is never a real producer, so it never creates a hazard
   function automatic logic load_use_hazard(input logic             ex_load,
                                            input logic [REG_W-1:0] ex_wsel,
                                            input logic [REG_W-1:0] id_rs,
                                            input logic [REG_W-1:0] id_rt,
                                            input logic             id_uses_rt);
      return ex_load && (ex_wsel != '0) &&
             ((ex_wsel == id_rs) || (id_uses_rt && (ex_wsel == id_rt)));
   endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and latch/PC controls exchanged between the datapath and pipeline_ctrl.
interface pipeline_ctrl_if;

   logic                                   ihit;
   logic                                   dhit;
   logic                                   mem_req;
   logic                                   ex_load;
   logic [pipeline_ctrl_pkg::REG_W-1:0]    ex_wsel;
   logic [pipeline_ctrl_pkg::REG_W-1:0]    id_rs;
   logic [pipeline_ctrl_pkg::REG_W-1:0]    id_rt;
   logic                                   id_uses_rt;
   logic                                   br_taken;
   logic                                   wb_halt;

   logic                                   pc_en;
   logic                                   ifid_en;
   logic                                   ifid_flush;
   logic                                   idex_en;
   logic                                   idex_flush;
   logic                                   idex_freeze;
   logic                                   exmem_en;
   logic                                   exmem_flush;
   logic                                   memwb_en;
   logic                                   memwb_flush;
   logic                                   halt_o;
   logic [pipeline_ctrl_pkg::CNT_W-1:0]    stall_cnt;
   logic [pipeline_ctrl_pkg::CNT_W-1:0]    flush_cnt;

   // Controller side
   modport pc (
      input  ihit, dhit, mem_req, ex_load, ex_wsel, id_rs, id_rt, id_uses_rt,
             br_taken, wb_halt,
      output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, idex_freeze,
             exmem_en, exmem_flush, memwb_en, memwb_flush, halt_o,
             stall_cnt, flush_cnt
   );

   modport slave (
      input  ihit, dhit, mem_req, ex_load, ex_wsel, id_rs, id_rt, id_uses_rt,
             br_taken, wb_halt,
      output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, idex_freeze,
             exmem_en, exmem_flush, memwb_en, memwb_flush, halt_o,
             stall_cnt, flush_cnt
   );

   // Datapath side
   modport master (
      output ihit, dhit, mem_req, ex_load, ex_wsel, id_rs, id_rt, id_uses_rt,
             br_taken, wb_halt,
      input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, idex_freeze,
             exmem_en, exmem_flush, memwb_en, memwb_flush, halt_o,
             stall_cnt, flush_cnt
   );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module pipeline_ctrl_sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the five-stage pipeline: memory-wait/halt FSM, same-cycle
// latch controls and saturating stall/flush performance counters.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
(
   input  logic     CLK,
   input  logic     nRST,
   pipeline_ctrl_if.pc bus
);

   ctrl_state_t state;
   ctrl_state_t state_nxt;
   ctrl_t       ctrl_c;
   logic        mem_wait_c;
   logic        load_use_c;
   logic        stall_inc_c;
   logic        flush_inc_c;

   assign mem_wait_c = bus.mem_req && !bus.dhit;
   assign load_use_c = load_use_hazard(bus.ex_load, bus.ex_wsel, bus.id_rs,
                                       bus.id_rt, bus.id_uses_rt);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state plus latch controls, highest-priority condition first
   always_comb begin
      state_nxt = state;
      ctrl_c    = CTRL_ADVANCE;

      unique case (state)
         RUN:     if (bus.wb_halt) state_nxt = HALT;
                  else if (mem_wait_c) state_nxt = MEMWAIT;
         MEMWAIT: if (bus.wb_halt) state_nxt = HALT;
                  else if (bus.dhit) state_nxt = RUN;
         HALT:    state_nxt = HALT;
         default: state_nxt = RUN;
      endcase

      if (state == HALT) begin
         ctrl_c = CTRL_ALL_OFF;
      end else if (mem_wait_c) begin
         // Everything holds; WB gets a bubble so the MEM instruction is not written twice
         ctrl_c             = CTRL_ALL_OFF;
         ctrl_c.memwb_flush = 1'b1;
      end else if (bus.br_taken) begin
         ctrl_c.ifid_flush = 1'b1;
         ctrl_c.idex_flush = 1'b1;
      end else if (load_use_c) begin
         ctrl_c.pc_en       = 1'b0;
         ctrl_c.ifid_en     = 1'b0;
         ctrl_c.idex_freeze = 1'b1;
      end else if (!bus.ihit) begin
         ctrl_c.pc_en      = 1'b0;
         ctrl_c.ifid_flush = 1'b1;
      end
   end

   assign bus.pc_en       = ctrl_c.pc_en;
   assign bus.ifid_en     = ctrl_c.ifid_en;
   assign bus.ifid_flush  = ctrl_c.ifid_flush;
   assign bus.idex_en     = ctrl_c.idex_en;
   assign bus.idex_flush  = ctrl_c.idex_flush;
   assign bus.idex_freeze = ctrl_c.idex_freeze;
   assign bus.exmem_en    = ctrl_c.exmem_en;
   assign bus.exmem_flush = ctrl_c.exmem_flush;
   assign bus.memwb_en    = ctrl_c.memwb_en;
   assign bus.memwb_flush = ctrl_c.memwb_flush;
   assign bus.halt_o      = (state == HALT);

   assign stall_inc_c = (state != HALT) && !ctrl_c.pc_en;
   assign flush_inc_c = ctrl_c.ifid_flush && bus.br_taken;

   pipeline_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (CLK),
      .rst_n (nRST),
      .inc   (stall_inc_c),
      .cnt   (bus.stall_cnt)
   );

   pipeline_ctrl_sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (CLK),
      .rst_n (nRST),
      .inc   (flush_inc_c),
      .cnt   (bus.flush_cnt)
   );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: table of single-cycle hazard vectors plus
// hand-written memory-wait, branch-during-wait, halt, reset and saturation sequences.
module tb_pipeline_ctrl;

   // Control word order: pc_en ifid_en ifid_flush idex_en idex_flush idex_freeze
   //                     exmem_en exmem_flush memwb_en memwb_flush
   localparam logic [9:0] C_ADV   = 10'b1101001010;
   localparam logic [9:0] C_LU    = 10'b0001011010;
   localparam logic [9:0] C_MISS  = 10'b0111001010;
   localparam logic [9:0] C_BR    = 10'b1111101010;
   localparam logic [9:0] C_WAIT  = 10'b0000000001;
   localparam logic [9:0] C_OFF   = 10'b0000000000;

   typedef struct {
      logic       ihit;
      logic       dhit;
      logic       mem_req;
      logic       ex_load;
      logic [4:0] ex_wsel;
      logic [4:0] id_rs;
      logic [4:0] id_rt;
      logic       id_uses_rt;
      logic       br_taken;
      logic [9:0] exp_ctrl;
   } vec_t;

   logic CLK;
   logic nRST;
   int   n_checks;
   int   n_pass;

   pipeline_ctrl_if bus ();

   pipeline_ctrl dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic [9:0] ctrl_act;
   assign ctrl_act = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_flush,
                      bus.idex_freeze, bus.exmem_en, bus.exmem_flush, bus.memwb_en,
                      bus.memwb_flush};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic ihit, input logic dhit, input logic mem_req,
                               input logic ex_load, input logic [4:0] wsel,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic uses_rt, input logic br,
                               input logic [9:0] exp_ctrl);
      vec_t v;
      v.ihit = ihit; v.dhit = dhit; v.mem_req = mem_req; v.ex_load = ex_load;
      v.ex_wsel = wsel; v.id_rs = rs; v.id_rt = rt; v.id_uses_rt = uses_rt;
      v.br_taken = br; v.exp_ctrl = exp_ctrl;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      bus.ihit = v.ihit; bus.dhit = v.dhit; bus.mem_req = v.mem_req;
      bus.ex_load = v.ex_load; bus.ex_wsel = v.ex_wsel; bus.id_rs = v.id_rs;
      bus.id_rt = v.id_rt; bus.id_uses_rt = v.id_uses_rt; bus.br_taken = v.br_taken;
   endtask

   task automatic set_idle();
      drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, C_ADV));
      bus.wb_halt = 1'b0;
   endtask

   // Pulse reset between clock edges so no edge is sampled while it is asserted
   task automatic do_reset();
      @(negedge CLK);
      nRST = 1'b0;
      set_idle();
      #2;
      nRST = 1'b1;
   endtask

   vec_t tbl[15];
   int   exp_stall;
   int   exp_flush;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_pass   = 0;
      nRST     = 1'b0;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_OFF));
      bus.wb_halt = 1'b0;

      // Reset state with all inputs low: fetch-miss pattern, counters clear
      #12;
      chk("reset_halt_o", 32'(bus.halt_o), 32'd0);
      chk("reset_stall_cnt", 32'(bus.stall_cnt), 32'd0);
      chk("reset_flush_cnt", 32'(bus.flush_cnt), 32'd0);
      chk("reset_ctrl", 32'(ctrl_act), 32'(C_MISS));

      tbl[0]  = mk(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, C_ADV);
      tbl[1]  = mk(1, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0, C_LU);
      tbl[2]  = mk(1, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0, C_ADV);
      tbl[3]  = mk(1, 0, 0, 1, 5'd7, 5'd3, 5'd7, 1, 0, C_LU);
      tbl[4]  = mk(1, 0, 0, 1, 5'd7, 5'd3, 5'd7, 0, 0, C_ADV);
      tbl[5]  = mk(1, 0, 0, 0, 5'd5, 5'd5, 5'd5, 1, 0, C_ADV);
      tbl[6]  = mk(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, C_MISS);
      tbl[7]  = mk(0, 0, 0, 1, 5'd9, 5'd9, 5'd1, 0, 0, C_LU);
      tbl[8]  = mk(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, C_BR);
      tbl[9]  = mk(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, C_BR);
      tbl[10] = mk(1, 0, 0, 1, 5'd4, 5'd4, 5'd0, 0, 1, C_BR);
      tbl[11] = mk(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, C_WAIT);
      tbl[12] = mk(1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, C_ADV);
      tbl[13] = mk(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 1, C_WAIT);
      tbl[14] = mk(1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 1, C_BR);

      @(negedge CLK);
      nRST      = 1'b1;
      exp_stall = 0;
      exp_flush = 0;
      for (int i = 0; i < 15; i++) begin
         drive(tbl[i]);
         #1;
         chk($sformatf("vec%0d_ctrl", i), 32'(ctrl_act), 32'(tbl[i].exp_ctrl));
         if (!tbl[i].exp_ctrl[9]) exp_stall++;
         if (tbl[i].exp_ctrl[7] && tbl[i].br_taken) exp_flush++;
         @(negedge CLK);
      end
      chk("table_stall_cnt", 32'(bus.stall_cnt), 32'(exp_stall));
      chk("table_flush_cnt", 32'(bus.flush_cnt), 32'(exp_flush));

      // Three wait cycles, then completion advances everything
      do_reset();
      bus.mem_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("wait%0d_ctrl", i), 32'(ctrl_act), 32'(C_WAIT));
         @(negedge CLK);
      end
      bus.dhit = 1'b1;
      #1;
      chk("wait_done_ctrl", 32'(ctrl_act), 32'(C_ADV));
      @(negedge CLK);
      set_idle();
      chk("wait_stall_cnt", 32'(bus.stall_cnt), 32'd3);
      chk("wait_halt_o", 32'(bus.halt_o), 32'd0);

      // Taken branch held during a wait, flushed on the dhit cycle
      do_reset();
      bus.br_taken = 1'b1;
      bus.mem_req  = 1'b1;
      #1;
      chk("brwait_hold_ctrl", 32'(ctrl_act), 32'(C_WAIT));
      @(negedge CLK);
      chk("brwait_flush_cnt_hold", 32'(bus.flush_cnt), 32'd0);
      bus.dhit = 1'b1;
      #1;
      chk("brwait_dhit_ctrl", 32'(ctrl_act), 32'(C_BR));
      @(negedge CLK);
      set_idle();
      chk("brwait_flush_cnt", 32'(bus.flush_cnt), 32'd1);
      chk("brwait_stall_cnt", 32'(bus.stall_cnt), 32'd1);

      // Halt: build some counts, halt, then controls stay off and counters freeze
      do_reset();
      bus.ihit = 1'b0;
      @(negedge CLK);
      bus.ihit     = 1'b1;
      bus.br_taken = 1'b1;
      @(negedge CLK);
      bus.br_taken = 1'b0;
      bus.wb_halt  = 1'b1;
      #1;
      chk("halt_pulse_halt_o", 32'(bus.halt_o), 32'd0);
      chk("halt_pulse_ctrl", 32'(ctrl_act), 32'(C_ADV));
      @(negedge CLK);
      bus.wb_halt = 1'b0;
      chk("halt_halt_o", 32'(bus.halt_o), 32'd1);
      for (int i = 0; i < 4; i++) begin
         bus.ihit     = 1'($urandom_range(0, 1));
         bus.dhit     = 1'($urandom_range(0, 1));
         bus.mem_req  = 1'($urandom_range(0, 1));
         bus.br_taken = 1'($urandom_range(0, 1));
         bus.ex_load  = 1'b1;
         bus.ex_wsel  = 5'd3;
         bus.id_rs    = 5'd3;
         #1;
         chk($sformatf("halt%0d_ctrl", i), 32'(ctrl_act), 32'(C_OFF));
         @(negedge CLK);
      end
      chk("halt_stall_cnt", 32'(bus.stall_cnt), 32'd1);
      chk("halt_flush_cnt", 32'(bus.flush_cnt), 32'd1);
      chk("halt_sticky", 32'(bus.halt_o), 32'd1);

      // Asynchronous reset while halted, checked before any clock edge
      set_idle();
      bus.ihit = 1'b0;
      #1;
      nRST = 1'b0;
      #1;
      chk("halt_rst_halt_o", 32'(bus.halt_o), 32'd0);
      chk("halt_rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
      chk("halt_rst_flush_cnt", 32'(bus.flush_cnt), 32'd0);
      chk("halt_rst_ctrl", 32'(ctrl_act), 32'(C_MISS));
      nRST = 1'b1;

      // Saturation: 2^16+5 fetch-miss cycles
      do_reset();
      bus.ihit = 1'b0;
      repeat (65534) @(negedge CLK);
      chk("sat_pre_stall_cnt", 32'(bus.stall_cnt), 32'h0000_FFFE);
      repeat (7) @(negedge CLK);
      chk("sat_stall_cnt", 32'(bus.stall_cnt), 32'h0000_FFFF);
      chk("sat_flush_cnt", 32'(bus.flush_cnt), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
